// File: rtl/branch_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// branch_hazard_ctrl_if
//
// Groups the branch hazard controller's pipeline-facing signals into one
// bundle. Signal names keep their i_/o_ prefixes so each one reads as seen
// from the controller.
//
//   ID stage      : i_valid_id, i_op, i_funct, i_rs_addr, i_rt_addr, i_taken
//   EX producer   : i_ex_reg_write, i_ex_mem_read, i_ex_rd_addr
//   MEM producer  : i_mem_mem_read, i_mem_rd_addr
//   debug         : i_halt
//   controls      : o_stall_pc, o_stall_if_id, o_bubble_id_ex, o_flush_if_id,
//                   o_branch_commit, o_busy
//   perf counter  : o_stall_cycles
//
// Modports:
//   master - the pipeline side. It drives the i_* signals and reads the o_* signals.
//   slave  - the controller side. It reads the i_* signals and drives the o_* signals.
// ---------------------------------------------------------------------------
interface branch_hazard_ctrl_if #(
    parameter int CNT_W  = 16,
    parameter int NB_OP  = 6,
    parameter int NB_REG = 5
);
    logic              i_valid_id;
    logic [NB_OP-1:0]  i_op;
    logic [NB_OP-1:0]  i_funct;
    logic [NB_REG-1:0] i_rs_addr;
    logic [NB_REG-1:0] i_rt_addr;
    logic              i_ex_reg_write;
    logic              i_ex_mem_read;
    logic [NB_REG-1:0] i_ex_rd_addr;
    logic              i_mem_mem_read;
    logic [NB_REG-1:0] i_mem_rd_addr;
    logic              i_taken;
    logic              i_halt;

    logic              o_stall_pc;
    logic              o_stall_if_id;
    logic              o_bubble_id_ex;
    logic              o_flush_if_id;
    logic              o_branch_commit;
    logic              o_busy;
    logic [CNT_W-1:0]  o_stall_cycles;

    modport master (
        output i_valid_id, i_op, i_funct, i_rs_addr, i_rt_addr,
               i_ex_reg_write, i_ex_mem_read, i_ex_rd_addr,
               i_mem_mem_read, i_mem_rd_addr, i_taken, i_halt,
        input  o_stall_pc, o_stall_if_id, o_bubble_id_ex, o_flush_if_id,
               o_branch_commit, o_busy, o_stall_cycles
    );

    modport slave (
        input  i_valid_id, i_op, i_funct, i_rs_addr, i_rt_addr,
               i_ex_reg_write, i_ex_mem_read, i_ex_rd_addr,
               i_mem_mem_read, i_mem_rd_addr, i_taken, i_halt,
        output o_stall_pc, o_stall_if_id, o_bubble_id_ex, o_flush_if_id,
               o_branch_commit, o_busy, o_stall_cycles
    );
endinterface

// File: rtl/branch_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// branch_hazard_ctrl
//
// Controls ID-stage branch and jump resolution in a 5-stage MIPS pipeline.
// A branch-class instruction (BEQ, BNE, JR, JALR, J, JAL) in ID may read a
// register that the instruction in EX or MEM has not produced yet. When that
// happens, the controller holds PC and IF/ID and feeds bubbles into ID/EX
// until forwarding can supply the operands. It then commits the branch and
// squashes IF/ID if the branch is taken. A saturating counter records the
// total number of branch stall cycles for the debug unit.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous reset, active-high
//   bus  - branch_hazard_ctrl_if.slave. It carries the ID, EX and MEM
//          stage information, the halt input, and all control outputs.
//
// Control outputs are Mealy: they depend on the FSM state and the current
// inputs. The FSM state, the stall down-counter and the performance counter
// are the only registers.
// ---------------------------------------------------------------------------
module branch_hazard_ctrl #(
    parameter int CNT_W  = 16,
    parameter int NB_OP  = 6,
    parameter int NB_REG = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_hazard_ctrl_if.slave   bus
);

    localparam logic [NB_OP-1:0] OP_SPECIAL = NB_OP'(6'b000000);
    localparam logic [NB_OP-1:0] OP_J       = NB_OP'(6'b000010);
    localparam logic [NB_OP-1:0] OP_JAL     = NB_OP'(6'b000011);
    localparam logic [NB_OP-1:0] OP_BEQ     = NB_OP'(6'b000100);
    localparam logic [NB_OP-1:0] OP_BNE     = NB_OP'(6'b000101);
    localparam logic [NB_OP-1:0] FN_JR      = NB_OP'(6'b001000);
    localparam logic [NB_OP-1:0] FN_JALR    = NB_OP'(6'b001001);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STALL   = 2'd1,
        RESOLVE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [1:0]       cnt, cnt_n;
    logic [CNT_W-1:0] stall_cycles;

    logic       is_branch, use_rs, use_rt;
    logic       ex_src, mem_src;
    logic [1:0] need;
    logic       stall, commit, flush;

    // A source register matches a producer only if it is not r0. Writes to r0
    // are discarded, so r0 never creates a dependency.
    function automatic logic reg_hit(input logic [NB_REG-1:0] src,
                                     input logic [NB_REG-1:0] dst);
        return (src == dst) && (src != '0);
    endfunction

    // Branch-class decode. It reports which source operands the instruction
    // reads during ID.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first. If any path leaves a signal unassigned, a latch is inferred.
        is_branch = 1'b0;
        use_rs    = 1'b0;
        use_rt    = 1'b0;
        case (bus.i_op)
            OP_BEQ, OP_BNE: begin
                is_branch = 1'b1;
                use_rs    = 1'b1;
                use_rt    = 1'b1;
            end
            OP_J, OP_JAL: begin
                is_branch = 1'b1;
            end
            OP_SPECIAL: begin
                if (bus.i_funct == FN_JR || bus.i_funct == FN_JALR) begin
                    is_branch = 1'b1;
                    use_rs    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Number of stall cycles needed before forwarding can supply the operands.
    // A load in EX returns its data two cycles later. An ALU result in EX, or
    // a load in MEM, is available one cycle later.
    always_comb begin
        ex_src  = (use_rs && reg_hit(bus.i_rs_addr, bus.i_ex_rd_addr)) ||
                  (use_rt && reg_hit(bus.i_rt_addr, bus.i_ex_rd_addr));
        mem_src = (use_rs && reg_hit(bus.i_rs_addr, bus.i_mem_rd_addr)) ||
                  (use_rt && reg_hit(bus.i_rt_addr, bus.i_mem_rd_addr));
        need    = 2'd0;
        if (ex_src && bus.i_ex_mem_read) begin
            need = 2'd2;
        end else if ((ex_src && bus.i_ex_reg_write) ||
                     (mem_src && bus.i_mem_mem_read)) begin
            need = 2'd1;
        end
    end

    // Next-state and Mealy output logic. Halt and reset both freeze the
    // sequence and hold the controls low. No action is taken in that case.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        stall   = 1'b0;
        commit  = 1'b0;
        flush   = 1'b0;
        if (!rst && !bus.i_halt) begin
            case (state)
                IDLE: begin
                    if (bus.i_valid_id && is_branch) begin
                        case (need)
                            2'd0: begin
                                commit = 1'b1;
                                flush  = bus.i_taken;
                            end
                            2'd1: begin
                                stall   = 1'b1;
                                state_n = RESOLVE;
                            end
                            default: begin
                                stall   = 1'b1;
                                cnt_n   = 2'd1;
                                state_n = STALL;
                            end
                        endcase
                    end
                end
                STALL: begin
                    stall = 1'b1;
                    cnt_n = cnt - 2'd1;
                    if (cnt == 2'd1) begin
                        state_n = RESOLVE;
                    end
                end
                RESOLVE: begin
                    // Forwarding now covers the operands, so the hazard is
                    // not checked again here.
                    commit  = 1'b1;
                    flush   = bus.i_taken;
                    state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: this reset is synchronous. It is sampled only on the clock
        // edge, so it must be held high across at least one rising edge.
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments. All
            // registers then update together from values sampled before the
            // clock edge.
            state        <= IDLE;
            cnt          <= 2'd0;
            stall_cycles <= '0;
        end else if (!bus.i_halt) begin
            state <= state_n;
            cnt   <= cnt_n;
            if (stall && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
        end
    end

    assign bus.o_stall_pc      = stall;
    assign bus.o_stall_if_id   = stall;
    assign bus.o_bubble_id_ex  = stall;
    assign bus.o_flush_if_id   = flush;
    assign bus.o_branch_commit = commit;
    assign bus.o_busy          = !rst && (state != IDLE);
    assign bus.o_stall_cycles  = stall_cycles;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_hazard_ctrl
//
// Self-checking bench for branch_hazard_ctrl. A compare process runs on every
// falling edge and checks the DUT against a behavioural model. The model
// tracks "cycles still to stall" and "commit pending" instead of FSM states.
// Directed sequences with hand-computed literal expectations anchor the model.
// A randomized phase follows them. CNT_W is reduced so that saturation can be
// reached within the test run.
// ---------------------------------------------------------------------------
module tb_branch_hazard_ctrl;

    localparam int CNT_W   = 4;
    localparam int NB_OP   = 6;
    localparam int NB_REG  = 5;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam int OP_SP = 0, OP_J = 2, OP_JAL = 3, OP_BEQ = 4, OP_BNE = 5;
    localparam int FN_JR = 8, FN_JALR = 9, FN_ADD = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_hazard_ctrl_if #(.CNT_W(CNT_W), .NB_OP(NB_OP), .NB_REG(NB_REG)) bus ();

    branch_hazard_ctrl #(.CNT_W(CNT_W), .NB_OP(NB_OP), .NB_REG(NB_REG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    bit model_armed = 0;
    bit in_flight   = 0;   // a detected branch is waiting to commit
    int stalls_left = 0;   // stall cycles still owed before that commit
    int stall_total = 0;

    function automatic int need_of(input int op, input int funct, input int rs, input int rt,
                                   input bit ex_wr, input bit ex_ld, input int ex_rd,
                                   input bit mem_ld, input int mem_rd);
        int srcs[$];
        int n = 0;
        if (op == OP_BEQ || op == OP_BNE) srcs = '{rs, rt};
        else if (op == OP_SP && (funct == FN_JR || funct == FN_JALR)) srcs = '{rs};
        foreach (srcs[i]) begin
            if (srcs[i] != 0) begin
                if (ex_ld && srcs[i] == ex_rd)           n = (n > 2) ? n : 2;
                else if (ex_wr && srcs[i] == ex_rd)      n = (n > 1) ? n : 1;
                if (mem_ld && srcs[i] == mem_rd)         n = (n > 1) ? n : 1;
            end
        end
        return n;
    endfunction

    function automatic bit branch_class(input int op, input int funct);
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_J) || (op == OP_JAL) ||
               (op == OP_SP && (funct == FN_JR || funct == FN_JALR));
    endfunction

    always @(negedge clk) begin
        logic [5:0] act_ctl;
        logic [5:0] exp_ctl;
        bit st, fl, cm, busy;
        int need;
        act_ctl = {bus.o_stall_pc, bus.o_stall_if_id, bus.o_bubble_id_ex,
                   bus.o_flush_if_id, bus.o_branch_commit, bus.o_busy};
        if (rst) begin
            if (model_armed) check("model_reset_ctl", {26'd0, act_ctl}, 32'd0);
            model_armed = 1;
            in_flight   = 0;
            stalls_left = 0;
            stall_total = 0;
        end else if (model_armed) begin
            st = 0; fl = 0; cm = 0;
            busy = in_flight;
            if (!bus.i_halt) begin
                if (!in_flight) begin
                    if (bus.i_valid_id && branch_class(int'(bus.i_op), int'(bus.i_funct))) begin
                        need = need_of(int'(bus.i_op), int'(bus.i_funct), int'(bus.i_rs_addr),
                                       int'(bus.i_rt_addr), bus.i_ex_reg_write, bus.i_ex_mem_read,
                                       int'(bus.i_ex_rd_addr), bus.i_mem_mem_read,
                                       int'(bus.i_mem_rd_addr));
                        if (need == 0) begin
                            cm = 1; fl = bus.i_taken;
                        end else begin
                            st = 1; in_flight = 1; stalls_left = need - 1;
                        end
                    end
                end else if (stalls_left > 0) begin
                    st = 1; stalls_left--;
                end else begin
                    cm = 1; fl = bus.i_taken; in_flight = 0;
                end
            end
            exp_ctl = {st, st, st, fl, cm, busy};
            check("model_ctl", {26'd0, act_ctl}, {26'd0, exp_ctl});
            check("model_stall_cycles", 32'(bus.o_stall_cycles), 32'(stall_total));
            if (st && stall_total < CNT_MAX) stall_total++;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers. Inputs change 1 ns after the rising edge. Literal
    // checks happen 2 ns later, well before the compare at the falling edge.
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_inputs();
        bus.i_valid_id     = 1'b0;
        bus.i_op           = '0;
        bus.i_funct        = '0;
        bus.i_rs_addr      = '0;
        bus.i_rt_addr      = '0;
        bus.i_ex_reg_write = 1'b0;
        bus.i_ex_mem_read  = 1'b0;
        bus.i_ex_rd_addr   = '0;
        bus.i_mem_mem_read = 1'b0;
        bus.i_mem_rd_addr  = '0;
        bus.i_taken        = 1'b0;
        bus.i_halt         = 1'b0;
    endtask

    task automatic set_instr(input int op, input int funct, input int rs, input int rt,
                             input bit taken);
        clear_inputs();
        bus.i_valid_id = 1'b1;
        bus.i_op       = op[NB_OP-1:0];
        bus.i_funct    = funct[NB_OP-1:0];
        bus.i_rs_addr  = rs[NB_REG-1:0];
        bus.i_rt_addr  = rt[NB_REG-1:0];
        bus.i_taken    = taken;
    endtask

    task automatic set_ex(input bit wr, input bit ld, input int rd);
        bus.i_ex_reg_write = wr;
        bus.i_ex_mem_read  = ld;
        bus.i_ex_rd_addr   = rd[NB_REG-1:0];
    endtask

    task automatic set_mem(input bit ld, input int rd);
        bus.i_mem_mem_read = ld;
        bus.i_mem_rd_addr  = rd[NB_REG-1:0];
    endtask

    // Compares the six 1-bit controls, plus the counter value, against literals.
    task automatic expect_out(input string name, input bit st, input bit fl, input bit cm,
                              input bit busy, input int cycles);
        logic [5:0] act;
        act = {bus.o_stall_pc, bus.o_stall_if_id, bus.o_bubble_id_ex,
               bus.o_flush_if_id, bus.o_branch_commit, bus.o_busy};
        check({name, "_ctl"}, {26'd0, act}, {26'd0, st, st, st, fl, cm, busy});
        check({name, "_cnt"}, 32'(bus.o_stall_cycles), 32'(cycles));
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        settle();
        expect_out("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;
        step();
        settle();
        expect_out("idle_after_reset", 0, 0, 0, 0, 0);

        // 1: BEQ without producers commits immediately.
        step(); set_instr(OP_BEQ, 0, 3, 3, 1); settle();
        expect_out("beq_no_hazard", 0, 1, 1, 0, 0);

        // 2: BNE with an EX ALU producer stalls for one cycle.
        step(); set_instr(OP_BNE, 0, 5, 6, 1); set_ex(1, 0, 5); settle();
        expect_out("bne_ex_alu_stall", 1, 0, 0, 0, 0);
        step(); set_ex(0, 0, 0); settle();
        expect_out("bne_ex_alu_commit", 0, 1, 1, 1, 1);

        // 3: JR with an EX load stalls for two cycles. Taken, then not taken.
        step(); set_instr(OP_SP, FN_JR, 7, 0, 1); set_ex(1, 1, 7); settle();
        expect_out("jr_ld_stall0", 1, 0, 0, 0, 1);
        step(); settle();
        expect_out("jr_ld_stall1", 1, 0, 0, 1, 2);
        step(); settle();
        expect_out("jr_ld_commit", 0, 1, 1, 1, 3);
        step(); set_instr(OP_SP, FN_JR, 7, 0, 0); set_ex(1, 1, 7); settle();
        expect_out("jr_nt_stall0", 1, 0, 0, 0, 3);
        step(); step(); settle();
        expect_out("jr_nt_commit", 0, 0, 1, 1, 5);

        // 4: a MEM load on rt stalls once. A producer writing r0 is ignored.
        step(); set_instr(OP_BEQ, 0, 1, 4, 0); set_mem(1, 4); settle();
        expect_out("beq_mem_ld_stall", 1, 0, 0, 0, 5);
        step(); settle();
        expect_out("beq_mem_ld_commit", 0, 0, 1, 1, 6);
        step(); set_instr(OP_BEQ, 0, 0, 9, 1); set_ex(1, 1, 0); settle();
        expect_out("beq_r0", 0, 1, 1, 0, 6);

        // 5: J ignores producers. ADD is not branch-class.
        step(); set_instr(OP_J, 0, 2, 2, 1); set_ex(1, 1, 2); settle();
        expect_out("j_no_stall", 0, 1, 1, 0, 6);
        step(); set_instr(OP_SP, FN_ADD, 2, 3, 1); set_ex(1, 1, 2); settle();
        expect_out("add_ignored", 0, 0, 0, 0, 6);

        // 6a: halt during STALL freezes the sequence for three cycles.
        step(); set_instr(OP_SP, FN_JALR, 8, 0, 1); set_ex(1, 1, 8); settle();
        expect_out("jalr_stall0", 1, 0, 0, 0, 6);
        for (int i = 0; i < 3; i++) begin
            step(); bus.i_halt = 1'b1; settle();
            expect_out("jalr_halted", 0, 0, 0, 1, 7);
        end
        step(); bus.i_halt = 1'b0; settle();
        expect_out("jalr_resume_stall", 1, 0, 0, 1, 7);
        step(); settle();
        expect_out("jalr_commit", 0, 1, 1, 1, 8);

        // 6b: reset during STALL returns the controller to idle.
        step(); set_instr(OP_SP, FN_JALR, 8, 0, 1); set_ex(1, 1, 8); settle();
        expect_out("jalr2_stall0", 1, 0, 0, 0, 8);
        step(); rst = 1'b1; settle();
        expect_out("rst_in_stall", 0, 0, 0, 0, 9);
        step(); rst = 1'b0; clear_inputs(); settle();
        expect_out("after_rst", 0, 0, 0, 0, 0);

        // The stall counter saturates.
        for (int i = 0; i < 20; i++) begin
            step(); set_instr(OP_BNE, 0, 5, 6, 0); set_ex(1, 0, 6);
            step(); clear_inputs();
        end
        step(); settle();
        expect_out("saturated", 0, 0, 0, 0, CNT_MAX);

        // Randomized phase. The model performs all the checking here.
        for (int i = 0; i < 3000; i++) begin
            int sel;
            step();
            clear_inputs();
            rst = ($urandom_range(0, 199) == 0);
            sel = $urandom_range(0, 7);
            case (sel)
                0: set_instr(OP_BEQ, $urandom_range(0, 63), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
                1: set_instr(OP_BNE, $urandom_range(0, 63), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
                2: set_instr(OP_SP, FN_JR, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
                3: set_instr(OP_SP, FN_JALR, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
                4: set_instr(OP_J, 0, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
                5: set_instr(OP_JAL, 0, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
                6: set_instr(OP_SP, FN_ADD, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
                default: set_instr($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
            endcase
            bus.i_valid_id = ($urandom_range(0, 4) != 0);
            set_ex(1'($urandom), 1'($urandom), $urandom_range(0, 3));
            set_mem(1'($urandom), $urandom_range(0, 3));
            bus.i_halt = ($urandom_range(0, 7) == 0);
        end

        step();
        rst = 1'b0;
        clear_inputs();
        step();
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
